// File: rtl/bw_io_ddr_vref_pkg.sv
// rtl/bw_io_ddr_vref_pkg.sv - shared types and defaults for the DDR vref code controller
package bw_io_ddr_vref_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_SETTLE,
    ST_DONE
  } vref_state_e;

  localparam int         VREF_CODE_W     = 7;
  localparam logic [6:0] VREF_RESET_CODE = 7'h40;

endpackage

// File: rtl/bw_io_ddr_vref_settle_cnt.sv
// rtl/bw_io_ddr_vref_settle_cnt.sv - loadable down-counter timing the post-step settle interval
module bw_io_ddr_vref_settle_cnt #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/bw_io_ddr_vref_code_ctl.sv
// rtl/bw_io_ddr_vref_code_ctl.sv - ramps the 7-bit DDR vref code toward a requested target
// BW_IO_DDR_VREF_RAMP_EN selects one-LSB stepping; without it each request is a single jump.
module bw_io_ddr_vref_code_ctl
  import bw_io_ddr_vref_pkg::*;
#(
  parameter int                CODE_W        = VREF_CODE_W,
  parameter int                SETTLE_CYCLES = 16,
  parameter logic [CODE_W-1:0] RESET_CODE    = CODE_W'(VREF_RESET_CODE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_vld,
  input  logic [CODE_W-1:0] cfg_code,
  output logic              cfg_rdy,
  output logic [CODE_W-1:0] vref_code,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  vref_state_e       state_q, state_d;
  logic [CODE_W-1:0] target_q, target_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  bw_io_ddr_vref_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    code_d   = code_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_vld) begin
          target_d = cfg_code;
          state_d  = (cfg_code == code_q) ? ST_DONE : ST_STEP;
        end
      end
      ST_STEP: begin
`ifdef BW_IO_DDR_VREF_RAMP_EN
        // Direction from comparison, so the code never wraps past 0 or full scale.
        if (code_q < target_q) begin
          code_d = code_q + CODE_W'(1);
        end else if (code_q > target_q) begin
          code_d = code_q - CODE_W'(1);
        end
`else
        code_d = target_q;
`endif
        cnt_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = (code_q == target_q) ? ST_DONE : ST_STEP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= RESET_CODE;
      code_q   <= RESET_CODE;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      code_q   <= code_d;
    end
  end

  assign cfg_rdy   = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign vref_code = code_q;

endmodule

// File: tb/tb_bw_io_ddr_vref_code_ctl.sv
// tb/tb_bw_io_ddr_vref_code_ctl.sv - scoreboard bench for the DDR vref code controller
module tb_bw_io_ddr_vref_code_ctl;

  localparam int S = 4;
`ifdef BW_IO_DDR_VREF_RAMP_EN
  localparam int RST_AT = 9;
`else
  localparam int RST_AT = 4;
`endif

  typedef struct {
    bit         is_done;
    logic [6:0] code;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_vld = 1'b0;
  logic [6:0] cfg_code = 7'h00;
  logic       cfg_rdy;
  logic [6:0] vref_code;
  logic       busy;
  logic       done;

  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  ev_t        exp_q[$];
  logic [6:0] model_code = 7'h40;
  logic [6:0] prev_code = 7'h40;

  bw_io_ddr_vref_code_ctl #(
    .CODE_W        (7),
    .SETTLE_CYCLES (S),
    .RESET_CODE    (7'h40)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_vld   (cfg_vld),
    .cfg_code  (cfg_code),
    .cfg_rdy   (cfg_rdy),
    .vref_code (vref_code),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected code-change and done events, placed on absolute cycles from the acceptance cycle.
  task automatic push_model(input int acc, input logic [6:0] tgt);
    int         d;
    logic [6:0] c;
    ev_t        e;
    c = model_code;
    d = (tgt > c) ? int'(tgt - c) : int'(c - tgt);
`ifdef BW_IO_DDR_VREF_RAMP_EN
    for (int k = 1; k <= d; k++) begin
      c = (tgt > c) ? c + 7'd1 : c - 7'd1;
      e.is_done = 1'b0; e.code = c; e.cyc = acc + (k - 1) * (S + 1) + 2;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.code = tgt; e.cyc = acc + d * (S + 1) + 1;
    exp_q.push_back(e);
`else
    if (d > 0) begin
      e.is_done = 1'b0; e.code = tgt; e.cyc = acc + 2;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1; e.code = tgt; e.cyc = (d == 0) ? acc + 1 : acc + S + 2;
    exp_q.push_back(e);
`endif
  endtask

  task automatic accept(input logic [6:0] c, output int acc);
    int n;
    n = 0;
    acc = -1;
    cfg_code = c;
    cfg_vld = 1'b1;
    while (!cfg_rdy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_rdy) begin
      tests++; fails++;
      $display("FAIL accept_timeout: cfg_rdy stayed 0 for code %0h", c);
    end else begin
      acc = cyc;
      push_model(acc, c);
      model_code = c;
    end
    @(negedge clk);
    cfg_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cfg_rdy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || !cfg_rdy) begin
      fails++;
      $display("FAIL idle_timeout: %0d events pending, cfg_rdy=%0b", exp_q.size(), cfg_rdy);
    end
  endtask

  task automatic check_event(input bit is_done);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: done=%0b code=%0h at cycle %0d, expected none", is_done, vref_code, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.code !== vref_code || e.cyc != cyc) begin
        fails++;
        $display("FAIL event: got done=%0b code=%0h cycle=%0d expected done=%0b code=%0h cycle=%0d",
                 is_done, vref_code, cyc, e.is_done, e.code, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_code = vref_code;
    end else begin
      tests++;
      if (done && cfg_rdy) begin
        fails++;
        $display("FAIL done_rdy_excl: done and cfg_rdy both 1 at cycle %0d, expected exclusive", cyc);
      end
      tests++;
      if (busy === cfg_rdy) begin
        fails++;
        $display("FAIL busy_rdy: busy=%0b cfg_rdy=%0b at cycle %0d, expected complementary", busy, cfg_rdy, cyc);
      end
      if (vref_code !== prev_code) check_event(1'b0);
      if (done) check_event(1'b1);
      prev_code = vref_code;
    end
  end

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk("reset_code", 32'(vref_code), 32'h40);
    chk("reset_rdy", 32'(cfg_rdy), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    accept(7'h43, acc); wait_idle();
    accept(7'h43, acc); wait_idle();
    accept(7'h00, acc); wait_idle();
    accept(7'h00, acc); wait_idle();
    chk("floor_code", 32'(vref_code), 32'h00);
    accept(7'h7F, acc); wait_idle();
    accept(7'h7F, acc); wait_idle();
    chk("ceiling_code", 32'(vref_code), 32'h7F);

    accept(7'h7C, acc);
    accept(7'h10, acc);
    wait_idle();
    chk("held_vld_code", 32'(vref_code), 32'h10);

    accept(7'h50, acc);
    while (cyc < acc + RST_AT) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    model_code = 7'h40;
    chk("midreset_code", 32'(vref_code), 32'h40);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_rdy", 32'(cfg_rdy), 32'd1);
    chk("midreset_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_reset_code", 32'(vref_code), 32'h40);

    accept(7'h7F, acc); wait_idle();
    chk("final_code", 32'(vref_code), 32'h7F);

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
